// File: rtl/button_debounce_irq.sv
// Eight-button synchroniser/debouncer with sticky change flags and a maskable interrupt.
// Optional saturating debounced-edge counter enabled by defining DEBOUNCE_EVENT_COUNT_EN.
module button_debounce_irq #(
  parameter int          TICK_DIV       = 1000,
  parameter int          DEBOUNCE_TICKS = 10,
  parameter logic [7:0]  INIT_LEVEL     = 8'hFF
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic [7:0] btn_raw,
  input  logic [7:0] irq_mask,
  input  logic       clr_valid,
  input  logic [7:0] clr_mask,
  output logic [7:0] btn_db,
  output logic [7:0] change,
  output logic       INT,
  output logic [7:0] event_count
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int             CW         = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_db;
  logic [7:0]    r_change;
  logic          r_int;
  logic [7:0]    w_accept;
  logic [7:0]    w_clr;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_clr  = clr_valid ? clr_mask : 8'h00;

  // Free-running sample prescaler; input activity never restarts it.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= INIT_LEVEL;
      r_sync2 <= INIT_LEVEL;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic [CW-1:0] r_cnt;
      logic          w_diff;

      assign w_diff       = (r_sync2[gi] != r_db[gi]);
      assign w_accept[gi] = w_diff && w_tick && (r_cnt == CNT_LAST);

      // Any sample agreeing with the accepted level restarts qualification.
      always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
          r_cnt <= '0;
        end else if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_tick) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

  // An accepted bit always differs from sync, so toggling adopts the new level.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_db     <= INIT_LEVEL;
      r_change <= 8'h00;
      r_int    <= 1'b0;
    end else begin
      r_db     <= r_db ^ w_accept;
      r_change <= (r_change & ~w_clr) | w_accept;
      r_int    <= |(r_change & irq_mask);
    end
  end

  assign btn_db = r_db;
  assign change = r_change;
  assign INT    = r_int;

`ifdef DEBOUNCE_EVENT_COUNT_EN
  logic [7:0] r_evt;
  logic [3:0] w_pop;
  logic [7:0] w_base;
  logic [8:0] w_sum;

  always_comb begin
    w_pop = 4'd0;
    for (int k = 0; k < 8; k++) begin
      w_pop = w_pop + {3'b000, w_accept[k]};
    end
  end

  // A full-mask clear restarts the count; same-cycle edges still add on top.
  assign w_base = (clr_valid && (clr_mask == 8'hFF)) ? 8'h00 : r_evt;
  assign w_sum  = {1'b0, w_base} + {5'b00000, w_pop};

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_evt <= 8'h00;
    end else begin
      r_evt <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign event_count = r_evt;
`else
  assign event_count = 8'h00;
`endif

endmodule

// File: tb/tb_button_debounce_irq.sv
// Bench for button_debounce_irq: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model based on tick counting per mismatch run.
module tb_button_debounce_irq;

  localparam int         TD   = 4;
  localparam int         DT   = 3;
  localparam logic [7:0] INIT = 8'hFF;

  logic       PCLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] btn_raw = 8'hFF;
  logic [7:0] irq_mask = 8'h00;
  logic       clr_valid = 1'b0;
  logic [7:0] clr_mask = 8'h00;
  logic [7:0] btn_db;
  logic [7:0] change;
  logic       INT;
  logic [7:0] event_count;

  button_debounce_irq #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DT),
    .INIT_LEVEL     (INIT)
  ) dut (
    .PCLK        (PCLK),
    .RESET       (RESET),
    .btn_raw     (btn_raw),
    .irq_mask    (irq_mask),
    .clr_valid   (clr_valid),
    .clr_mask    (clr_mask),
    .btn_db      (btn_db),
    .change      (change),
    .INT         (INT),
    .event_count (event_count)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Model: a level is accepted at the edge where the DT-th prescaler tick falls
  // inside an unbroken run of edges in which the synchronised pin differs from it.
  logic [7:0] m_s1, m_s2, m_db, m_change;
  logic       m_int;
  int         m_evt;
  int         m_n;
  int         m_start [8];

  function automatic bit will_accept(input int b);
    int st;
    if (m_s2[b] == m_db[b]) return 1'b0;
    st = (m_start[b] < 0) ? m_n : m_start[b];
    return ((m_n % TD) == TD - 1) && (((m_n + 1) / TD - st / TD) == DT);
  endfunction

  always @(posedge PCLK) begin
    logic [7:0] acc;
    logic [7:0] clr;
    logic [7:0] exp_evt;
    int         base;
    int         ticks;
    if (RESET) begin
      m_s1 = INIT; m_s2 = INIT; m_db = INIT; m_change = 8'h00;
      m_int = 1'b0; m_evt = 0; m_n = 0;
      for (int b = 0; b < 8; b++) m_start[b] = -1;
    end else begin
      acc = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (m_s2[b] == m_db[b]) begin
          m_start[b] = -1;
        end else begin
          if (m_start[b] < 0) m_start[b] = m_n;
          ticks = (m_n + 1) / TD - m_start[b] / TD;
          if (((m_n % TD) == TD - 1) && (ticks == DT)) begin
            acc[b] = 1'b1;
            m_start[b] = -1;
          end
        end
      end
      clr      = clr_valid ? clr_mask : 8'h00;
      m_int    = |(m_change & irq_mask);
      m_change = (m_change & ~clr) | acc;
      base     = (clr_valid && clr_mask == 8'hFF) ? 0 : m_evt;
      m_evt    = base + $countones(acc);
      if (m_evt > 255) m_evt = 255;
      m_db     = m_db ^ acc;
      m_s2     = m_s1;
      m_s1     = btn_raw;
      m_n++;
    end
    #1;
`ifdef DEBOUNCE_EVENT_COUNT_EN
    exp_evt = m_evt[7:0];
`else
    exp_evt = 8'h00;
`endif
    check("cyc_btn_db", {24'd0, btn_db}, {24'd0, m_db});
    check("cyc_change", {24'd0, change}, {24'd0, m_change});
    check("cyc_int", {31'd0, INT}, {31'd0, m_int});
    check("cyc_event_count", {24'd0, event_count}, {24'd0, exp_evt});
  end

  task automatic negs(input int k);
    repeat (k) @(negedge PCLK);
  endtask

  initial begin
    int lat;
    bit found;

    RESET = 1'b1;
    negs(3);
    RESET = 1'b0;

    // Idle buttons stay quiet.
    irq_mask = 8'h01;
    negs(50);
    check("idle_btn_db", {24'd0, btn_db}, 32'h0000_00FF);
    check("idle_change", {24'd0, change}, 32'h0);
    check("idle_int", {31'd0, INT}, 32'h0);

    // Clean step on bit 0.
    btn_raw[0] = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge PCLK); #2;
      lat++;
      if (btn_db[0] == 1'b0) break;
    end
    check_range("step0_latency", lat, 11, 14);
    check("step0_change", {24'd0, change}, 32'h01);
    check("step0_int_not_yet", {31'd0, INT}, 32'h0);
    @(posedge PCLK); #2;
    check("step0_int", {31'd0, INT}, 32'h1);

    // Short bounces on bit 3 never qualify.
    for (int r = 0; r < 5; r++) begin
      @(negedge PCLK); btn_raw[3] = 1'b0;
      negs(6);
      btn_raw[3] = 1'b1;
      negs(6);
    end
    check("bounce_db3", {31'd0, btn_db[3]}, 32'h1);
    check("bounce_change", {24'd0, change}, 32'h01);

    // Selective clearing.
    btn_raw[3] = 1'b0;
    negs(20);
    check("clr_pre_change", {24'd0, change}, 32'h09);
    clr_valid = 1'b1; clr_mask = 8'h08;
    @(negedge PCLK); clr_valid = 1'b0;
    check("clr8_change", {24'd0, change}, 32'h01);
    @(negedge PCLK);
    check("clr8_int", {31'd0, INT}, 32'h1);
    clr_valid = 1'b1; clr_mask = 8'h01;
    @(negedge PCLK); clr_valid = 1'b0;
    check("clr1_change", {24'd0, change}, 32'h00);
    check("clr1_int_lag", {31'd0, INT}, 32'h1);
    @(negedge PCLK);
    check("clr1_int", {31'd0, INT}, 32'h0);

    // Clear coinciding with the edge on bit 2: set wins.
    btn_raw[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (will_accept(2)) begin
        clr_valid = 1'b1; clr_mask = 8'h04;
        @(negedge PCLK);
        clr_valid = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("collide_found", {31'd0, found}, 32'h1);
    check("collide_db2", {31'd0, btn_db[2]}, 32'h0);
    check("collide_change", {24'd0, change}, 32'h04);

    // Restore idle, clear everything, then reset mid-qualification on bit 5.
    btn_raw = 8'hFF;
    negs(20);
    clr_valid = 1'b1; clr_mask = 8'hFF;
    @(negedge PCLK); clr_valid = 1'b0;
    btn_raw[5] = 1'b0;
    negs(8);
    RESET = 1'b1;
    #1;
    check("rst_btn_db", {24'd0, btn_db}, 32'hFF);
    check("rst_change", {24'd0, change}, 32'h00);
    negs(2);
    RESET = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge PCLK); #2;
      lat++;
      if (btn_db[5] == 1'b0) break;
    end
    check_range("rst_requal_latency", lat, 11, 14);
`ifdef DEBOUNCE_EVENT_COUNT_EN
    check("rst_event_count", {24'd0, event_count}, 32'h1);
`else
    check("rst_event_count_tied", {24'd0, event_count}, 32'h0);
`endif

    // All eight buttons toggling together, 40 times: 320 edges saturate the count.
    @(negedge PCLK);
    for (int r = 0; r < 40; r++) begin
      btn_raw = ~btn_raw;
      negs(20);
      check("multi_db_follows", {24'd0, btn_db}, {24'd0, btn_raw});
    end
`ifdef DEBOUNCE_EVENT_COUNT_EN
    check("sat_event_count", {24'd0, event_count}, 32'hFF);
`endif

    // Randomized activity.
    for (int i = 0; i < 4000; i++) begin
      @(negedge PCLK);
      clr_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(47, 0) == 0) btn_raw[b] = ~btn_raw[b];
      end
      if ($urandom_range(199, 0) == 0) irq_mask = 8'($urandom);
      if ($urandom_range(15, 0) == 0) begin
        clr_valid = 1'b1;
        clr_mask  = ($urandom_range(7, 0) == 0) ? 8'hFF : 8'($urandom);
      end else begin
        clr_mask = 8'($urandom);
      end
      if ($urandom_range(1499, 0) == 0) begin
        RESET = 1'b1;
        negs(2);
        RESET = 1'b0;
      end
    end

    @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
